// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match-vector iterator.
package cam_pkg;

    // Default match vector width (one bit per CAM entry) and index width
    localparam int WIDTH_DEF = 16;
    localparam int IDX_W_DEF = 4;

    // Iterator states: waiting for a lookup, or emitting its indices
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Popcount needs one more bit than an index so a full vector fits
    typedef logic [IDX_W_DEF:0] count_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational lowest-set-bit encoder.
module cam_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_match_iter.sv
// Captures a CAM match vector and streams the index of each set bit,
// lowest first; an all-zero vector yields a single miss beat.
module cam_match_iter
    import cam_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             match_valid,
    input  logic [WIDTH-1:0] match_vec,
    output logic             match_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             idx_miss,
    input  logic             idx_ready,
    output logic [IDX_W:0]   match_count
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] enc_in;
    logic [WIDTH-1:0] enc_cleared;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [IDX_W:0]   pop;

    // Single encoder shared by capture (new vector) and advance (remaining bits)
    assign enc_in      = (state == IDLE) ? match_vec : pending;
    assign enc_cleared = enc_in & (enc_in - WIDTH'(1));

    cam_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Popcount of the incoming vector, only registered at capture
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{IDX_W{1'b0}}, match_vec[i]};
        end
    end

    // State register; ena low freezes the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next state: capture moves to EMIT, accepting the last beat returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (match_valid)           state_next = EMIT;
            EMIT: if (idx_ready && idx_last) state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Handshake flags are pure functions of the registered state
    always_comb begin
        match_ready = (state == IDLE);
        idx_valid   = (state == EMIT);
    end

    // Beat registers: load on capture, step on each accepted non-final beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            idx         <= '0;
            idx_last    <= 1'b0;
            idx_miss    <= 1'b0;
            match_count <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (match_valid) begin
                        pending     <= enc_cleared;
                        idx         <= enc_idx;
                        idx_miss    <= ~enc_any;
                        idx_last    <= ~enc_any | (enc_cleared == '0);
                        match_count <= pop;
                    end
                end
                EMIT: begin
                    if (idx_ready) begin
                        if (idx_last) begin
                            idx_last <= 1'b0;
                            idx_miss <= 1'b0;
                        end else begin
                            pending  <= enc_cleared;
                            idx      <= enc_idx;
                            idx_last <= (enc_cleared == '0);
                        end
                    end
                end
                default: begin
                    idx_last <= 1'b0;
                    idx_miss <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_match_iter.sv
// Directed testbench for cam_match_iter.
module tb_cam_match_iter;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        match_valid;
    logic [15:0] match_vec;
    logic        match_ready;
    logic        idx_valid;
    logic [3:0]  idx;
    logic        idx_last;
    logic        idx_miss;
    logic        idx_ready;
    logic [4:0]  match_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [12:0] obs;
    assign obs = {match_ready, idx_valid, idx, idx_last, idx_miss, match_count};

    cam_match_iter #(.WIDTH(16), .IDX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .match_valid (match_valid),
        .match_vec   (match_vec),
        .match_ready (match_ready),
        .idx_valid   (idx_valid),
        .idx         (idx),
        .idx_last    (idx_last),
        .idx_miss    (idx_miss),
        .idx_ready   (idx_ready),
        .match_count (match_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds the expected {ready, valid, idx, last, miss, count} tuple
    function automatic logic [12:0] pack(input logic mr, input logic v, input logic [3:0] i,
                                         input logic l, input logic m, input logic [4:0] c);
        return {mr, v, i, l, m, c};
    endfunction

    // Advance one rising edge, then settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp_v;
        rst = 1'b1; ena = 1'b1; match_valid = 1'b0; match_vec = '0; idx_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_v = pack(1, 0, 4'd0, 0, 0, 5'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_miss();
        logic [12:0] exp_v;
        match_vec = 16'h0000; match_valid = 1'b1; idx_ready = 1'b0;
        tick();
        match_valid = 1'b0;
        exp_v = pack(0, 1, 4'd0, 1, 1, 5'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL miss_beat: got %h expected %h", obs, exp_v);
        end
        idx_ready = 1'b1;
        tick();
        idx_ready = 1'b0;
        exp_v = pack(1, 0, 4'd0, 0, 0, 5'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL miss_return_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sparse();
        logic [12:0] exp_v;
        logic [3:0]  exp_idx [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        match_vec = 16'h8421; match_valid = 1'b1; idx_ready = 1'b1;
        tick();
        match_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            exp_v = pack(0, 1, exp_idx[j], (j == 3), 0, 5'd4);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL sparse_beat%0d: got %h expected %h", j, obs, exp_v);
            end
            tick();
        end
        exp_v = pack(1, 0, 4'd15, 0, 0, 5'd4);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL sparse_end: got %h expected %h", obs, exp_v);
        end
        idx_ready = 1'b0;
    endtask

    task automatic test_full_backpressure();
        logic [12:0] exp_v;
        match_vec = 16'hFFFF; match_valid = 1'b1; idx_ready = 1'b0;
        tick();
        match_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_v = pack(0, 1, 4'(k), (k == 15), 0, 5'd16);
            idx_ready = 1'b0;
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL full_stall_beat%0d: got %h expected %h", k, obs, exp_v);
            end
            idx_ready = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL full_beat%0d: got %h expected %h", k, obs, exp_v);
            end
            tick();
        end
        idx_ready = 1'b0;
        exp_v = pack(1, 0, 4'd15, 0, 0, 5'd16);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL full_end: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_enable_stall();
        logic [12:0] exp_v;
        match_vec = 16'h0006; match_valid = 1'b1; idx_ready = 1'b1; ena = 1'b1;
        tick();
        match_valid = 1'b0;
        match_vec   = 16'hFFFF;
        exp_v = pack(0, 1, 4'd1, 0, 0, 5'd2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL ena_first_beat: got %h expected %h", obs, exp_v);
        end
        ena = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL ena_stall%0d: got %h expected %h", s, obs, exp_v);
            end
        end
        ena = 1'b1;
        tick();
        exp_v = pack(0, 1, 4'd2, 1, 0, 5'd2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL ena_second_beat: got %h expected %h", obs, exp_v);
        end
        tick();
        idx_ready = 1'b0;
        match_vec = 16'h0000;
        exp_v = pack(1, 0, 4'd2, 0, 0, 5'd2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL ena_end: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_top_bit();
        logic [12:0] exp_v;
        match_vec = 16'h8000; match_valid = 1'b1; idx_ready = 1'b1;
        tick();
        match_valid = 1'b0;
        exp_v = pack(0, 1, 4'd15, 1, 0, 5'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL top_bit_beat: got %h expected %h", obs, exp_v);
        end
        tick();
        idx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [12:0] exp_v;
        match_vec = 16'h00F0; match_valid = 1'b1; idx_ready = 1'b1;
        tick();
        match_valid = 1'b0;
        exp_v = pack(0, 1, 4'd4, 0, 0, 5'd4);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_burst_beat0: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = pack(0, 1, 4'd5, 0, 0, 5'd4);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_burst_beat1: got %h expected %h", obs, exp_v);
        end
        rst = 1'b1;
        #1;
        exp_v = pack(1, 0, 4'd0, 0, 0, 5'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_async_clear: got %h expected %h", obs, exp_v);
        end
        tick();
        rst = 1'b0;
        match_vec = 16'h0001; match_valid = 1'b1;
        tick();
        match_valid = 1'b0;
        exp_v = pack(0, 1, 4'd0, 1, 0, 5'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_after_single: got %h expected %h", obs, exp_v);
        end
        tick();
        exp_v = pack(1, 0, 4'd0, 0, 0, 5'd1);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rst_after_idle: got %h expected %h", obs, exp_v);
        end
        idx_ready = 1'b0;
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_miss();
        test_sparse();
        test_full_backpressure();
        test_enable_stall();
        test_top_bit();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_match_iter.md
# cam_match_iter

Match-vector iterator that sits directly downstream of the CAM lookup stage. It captures one 16-bit match vector per lookup and emits the index of every set bit, lowest first, one per beat over a valid/ready stream. The result is a serial address stream that a narrow output port or a host-side reader can drain. A zero vector produces a single explicit miss beat, so every lookup yields at least one beat.

## Interface
- `WIDTH`, default 16: match vector width, one bit per CAM entry.
- `IDX_W`, default 4: index width, equal to log2(`WIDTH`).

- `clk`  in  1: sole clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: global enable; when low, all state and outputs freeze.
- `match_valid`  in  1: `match_vec` holds a new lookup result.
- `match_vec`  in  `WIDTH`: match vector; bit i set means entry i matched.
- `match_ready`  out  1: block can accept a vector.
- `idx_valid`  out  1: an output beat is presented.
- `idx`  out  `IDX_W`: index of the current matching entry.
- `idx_last`  out  1: final beat for the captured vector.
- `idx_miss`  out  1: captured vector was all-zero; `idx` is 0 on this beat.
- `idx_ready`  in  1: downstream accepts the beat.
- `match_count`  out  `IDX_W+1`: popcount of the captured vector, stable for the whole burst.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - `match_ready`=1, `idx_valid`=0.
  - On `ena & match_valid`:
    - Load the vector into `pending`, with its lowest set bit cleared.
    - Load `idx` with that bit's position.
    - Load `match_count` with the popcount.
    - Go to EMIT.
  - A zero vector instead loads `idx`=0, `idx_miss`=1, `idx_last`=1, `match_count`=0.
- EMIT:
  - `match_ready`=0, `idx_valid`=1.
  - `idx_last` = (`pending`==0) or miss.
  - On `ena & idx_ready` with `idx_last`=0: load `idx` with the lowest set bit of `pending`, clear that bit, stay in EMIT.
  - On `ena & idx_ready` with `idx_last`=1: go to IDLE and clear `idx_valid`, `idx_miss`, `idx_last`.
- Output stability: `idx`, `idx_last`, `idx_miss` and `match_count` are registered. They hold constant while `idx_valid & ~idx_ready`.
- `match_vec` is sampled only at capture; later changes have no effect on the burst.
- `ena` low:
  - No capture, no advance, no state change.
  - `match_ready` and `idx_valid` keep their values.
  - A handshake is counted only when `ena`=1.
- Bit `WIDTH-1` set alone: `idx`=15, `idx_last`=1.
- All bits set: 16 beats, indices 0..15, and `match_count`=16, which requires the `IDX_W+1` width.

## Timing
- Reset values:
  - State IDLE, `match_ready`=1.
  - `idx_valid`=0, `idx`=0, `idx_last`=0, `idx_miss`=0.
  - `match_count`=0, `pending`=0.
- Asserting `rst` mid-burst aborts the burst immediately. All remaining beats are lost.
- Latency: capture at edge N puts the first beat valid after edge N, i.e. in cycle N+1.
- Throughput: with `idx_ready` held high, a vector with k set bits occupies k EMIT cycles plus 1 IDLE capture cycle. A miss occupies 1 EMIT cycle.
- `match_ready` depends only on state, with no combinational path from `idx_ready`.
- There is no combinational path from any input to any output.

## Structure
- `cam_pkg` holds:
  - `WIDTH` and `IDX_W` defaults.
  - The state enum (IDLE, EMIT).
  - A `count_t` typedef of width `IDX_W+1`.
- Sub-module `cam_prio_enc`: a purely combinational lowest-set-bit encoder.
  - Input: `WIDTH` vector.
  - Outputs: `IDX_W` index and an `any` flag.
  - Instanced once, fed from the capture mux: `match_vec` in IDLE, `pending` in EMIT.
- Popcount is computed inline at capture.

## Test plan
- Reset, then `match_vec`=16'h0000 with `match_valid` pulsed → one beat: `idx`=0, `idx_miss`=1, `idx_last`=1, `match_count`=0; `match_ready` high in the following cycle.
- `match_vec`=16'h8421, `idx_ready`=1 → `idx` 0, 5, 10, 15 on consecutive cycles; `idx_last` only on 15; `match_count`=4.
- `match_vec`=16'hFFFF, `idx_ready` toggled 1,0,1,0 → 16 beats 0..15 in order; outputs frozen on every `idx_ready`=0 cycle; `match_count`=16.
- `match_vec`=16'h0006, `ena` dropped for 3 cycles after the first beat → `idx`=1 held through the stall, then `idx`=2 with `idx_last`; `match_vec` changed mid-burst has no effect.
- `match_vec`=16'h00F0, `rst` asserted after the second beat → all outputs at reset values in the same cycle; next vector 16'h0001 yields a single beat `idx`=0, `idx_last`=1, `idx_miss`=0.
